// File: rtl/frame_control_pkg.sv
// Shared definitions for the frame sequencer: state encoding, width helpers
// and parameter legality checks.
package frame_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Channel index is never narrower than one bit, even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : clog2(num_ch);
    endfunction

    function automatic bit params_ok(input int sub_w, input int addr_w, input int num_ch);
        return (addr_w > sub_w) && (num_ch >= 1);
    endfunction

endpackage

// File: rtl/frame_control_if.sv
// Control/status bundle between system control (master) and the frame sequencer (slave).
interface frame_control_if #(
    parameter int ADDR_W = 9,
    parameter int CH_W   = 1
);
    logic              start;
    logic              stop;
    logic              mode;
    logic              hold;
    logic [ADDR_W-1:0] last_adrs;
    logic [ADDR_W-1:0] ramadrs;
    logic [CH_W-1:0]   chan;
    logic              oeenable;
    logic              outstrobe;
    logic              txc;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, mode, hold, last_adrs,
        input  ramadrs, chan, oeenable, outstrobe, txc, busy, done
    );

    modport slave (
        input  start, stop, mode, hold, last_adrs,
        output ramadrs, chan, oeenable, outstrobe, txc, busy, done
    );
endinterface

// File: rtl/frame_addr_counter.sv
// Frame address counter: advances when enabled, returns to zero at the
// terminal address, and is cleared while the sequencer is idle.
module frame_addr_counter #(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] cnt,
    output logic              frame_end
);
    assign frame_end = (cnt == last);

    always_ff @(posedge clock) begin
        if (!reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= frame_end ? '0 : cnt + ADDR_W'(1);
    end
endmodule

// File: rtl/frame_control.sv
// Frame sequencer: sweeps ramadrs 0..last_q over NUM_CH channels per pass,
// single-shot or continuous, with hold/stop control and registered strobes.
module frame_control
    import frame_ctrl_pkg::*;
#(
    parameter int SUB_W  = 4,
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 2
) (
    input  logic            clock,
    input  logic            reset,
    frame_control_if.slave  bus
);
    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    generate
        if (!params_ok(SUB_W, ADDR_W, NUM_CH)) begin : g_bad_params
            $error("frame_control: need ADDR_W > SUB_W and NUM_CH >= 1");
        end
    endgenerate

    state_t            state, state_n;
    logic [CH_W-1:0]   chan, chan_n;
    logic              stop_pend, pend_n;
    logic              mode_q, mode_n;
    logic [ADDR_W-1:0] last_q, last_n;
    logic              oe_q, oe_n;
    logic              os_q, os_n;
    logic              done_q, done_n;
    logic              cnt_en;
    logic [ADDR_W-1:0] ramadrs;
    logic              frame_end;

    frame_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .en        (cnt_en),
        .clr       (state == ST_IDLE),
        .last      (last_q),
        .cnt       (ramadrs),
        .frame_end (frame_end)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            chan      <= '0;
            stop_pend <= 1'b0;
            mode_q    <= 1'b0;
            last_q    <= '0;
            oe_q      <= 1'b0;
            os_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            chan      <= chan_n;
            stop_pend <= pend_n;
            mode_q    <= mode_n;
            last_q    <= last_n;
            oe_q      <= oe_n;
            os_q      <= os_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        chan_n  = chan;
        pend_n  = stop_pend;
        mode_n  = mode_q;
        last_n  = last_q;
        done_n  = 1'b0;
        oe_n    = 1'b0;
        os_n    = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                chan_n = '0;
                if (bus.start) begin
                    state_n = ST_RUN;
                    pend_n  = bus.stop;
                    mode_n  = bus.mode;
                    last_n  = bus.last_adrs;
                end
            end
            ST_RUN: begin
                pend_n = stop_pend | bus.stop;
                if (!bus.hold) begin
                    cnt_en = 1'b1;
                    if (frame_end) begin
                        if (chan == CH_LAST) begin
                            chan_n = '0;
                            if (!mode_q || stop_pend) begin
                                state_n = ST_IDLE;
                                done_n  = 1'b1;
                                pend_n  = 1'b0;
                            end
                        end else begin
                            chan_n = chan + CH_W'(1);
                        end
                    end
                    // Strobes are suppressed when this cycle ends the run.
                    if (state_n == ST_RUN) begin
                        oe_n = (ramadrs[SUB_W:0] == '0);
                        os_n = &ramadrs[ADDR_W-1:SUB_W];
                    end
                end
            end
        endcase
    end

    assign bus.ramadrs   = ramadrs;
    assign bus.chan      = chan;
    assign bus.oeenable  = oe_q;
    assign bus.outstrobe = os_q;
    assign bus.txc       = ramadrs[SUB_W];
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = done_q;

endmodule
